// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer plus a mid-bit sampling FSM.
// Reports good bytes on rdata/rx_ready and framing errors on ferr.
module uart_rx_core #(
    parameter int unsigned CLK_PER_HALF_BIT = 521
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr,
    output logic       rx_busy
);

    localparam logic [31:0] HALF_LAST = 32'(CLK_PER_HALF_BIT - 1);
    localparam logic [31:0] BIT_LAST  = 32'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [7:0]  rdata_nxt;
    logic        ready_nxt;
    logic        ferr_nxt;
    logic        sync1;
    logic        line;

    // Synchronizer resets to the idle (high) level so reset release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= rxd;
            line  <= sync1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only; all combinational decisions live below.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            rdata    <= 8'h00;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shift    <= shift_nxt;
            rdata    <= rdata_nxt;
            rx_ready <= ready_nxt;
            ferr     <= ferr_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        rdata_nxt = rdata;
        ready_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (line == 1'b0) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end

            // Re-check the line at mid start bit; a short glitch reads high here and is dropped.
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (line == 1'b0) begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end

            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = line;
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end

            // Leaving at mid stop bit gives half a bit of slack to catch a back-to-back start bit.
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (line == 1'b1) begin
                        rdata_nxt = shift;
                        ready_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end

            S_WAIT_HIGH: begin
                if (line == 1'b1) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at H=4: expected events are queued as frames
// are driven and popped by a monitor when rx_ready or ferr pulses.
module tb_uart_rx_core;

    localparam int H   = 4;
    localparam int BIT = 2 * H;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rdata;
    logic       rx_ready;
    logic       ferr;
    logic       rx_busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ready_cyc = 0;
    logic prev_busy = 1'b0;
    logic [7:0] last_good = 8'h00;
    exp_t exp_q[$];

    uart_rx_core #(.CLK_PER_HALF_BIT(H)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_ready (rx_ready),
        .ferr     (ferr),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serial transmitter model: start bit, 8 data bits LSB first, stop bit.
    task automatic uart_tx(input logic [7:0] b, input logic stop_level);
        rxd = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(BIT);
        end
        rxd = stop_level;
        wait_cycles(BIT);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back('{is_err: 1'b0, data: b});
        last_good = b;
        uart_tx(b, 1'b1);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rx_ready && ferr) check("both_pulses", 32'd1, 32'd0);
        if (rx_ready || ferr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, rx_ready, ferr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {30'd0, rx_ready, ferr}, e.is_err ? 32'd1 : 32'd2);
                check("rdata", {24'd0, rdata}, {24'd0, e.data});
                if (rx_ready) begin
                    check("busy_fall", {30'd0, prev_busy, rx_busy}, 32'd2);
                    ready_cyc = cyc;
                end
            end
        end
        prev_busy = rx_busy;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_cyc;
        int lat;

        // Reset state
        wait_cycles(3);
        check("rst_rdata", {24'd0, rdata}, 32'h00);
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        rstn = 1'b1;
        wait_cycles(5);

        // Single frame with latency measurement
        fall_cyc = cyc;
        send_good(8'hA5);
        lat = ready_cyc - fall_cyc - 1;
        check("latency_19h2", {31'd0, (lat >= 19 * H + 1 && lat <= 19 * H + 3)}, 32'd1);
        check("a5_held", {24'd0, rdata}, 32'hA5);
        wait_cycles(10);

        // Back-to-back frames
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h3C);
        wait_cycles(10);
        check("b2b_last", {24'd0, rdata}, 32'h3C);

        // Framing error followed by a break
        exp_q.push_back('{is_err: 1'b1, data: last_good});
        uart_tx(8'h55, 1'b0);
        wait_cycles(40);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        wait_cycles(4);
        check("break_idle", {31'd0, rx_busy}, 32'd0);
        check("ferr_rdata_kept", {24'd0, rdata}, 32'h3C);
        wait_cycles(10);

        // Short glitch on idle line
        rxd = 1'b0;
        wait_cycles(2);
        rxd = 1'b1;
        wait_cycles(H + 3);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);
        wait_cycles(10);

        // Reset during data bit 4 of 8'hC3
        rxd = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'hC3 >> i) & 8'h01;
            wait_cycles(BIT);
        end
        rxd = 1'b0;
        wait_cycles(H);
        check("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        rstn = 1'b0;
        rxd = 1'b1;
        wait_cycles(3);
        check("midrst_rdata", {24'd0, rdata}, 32'h00);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        rstn = 1'b1;
        last_good = 8'h00;
        wait_cycles(20);
        check("post_rst_idle", {31'd0, rx_busy}, 32'd0);
        send_good(8'h81);
        wait_cycles(10);
        check("after_rst_81", {24'd0, rdata}, 32'h81);

        // Loopback of every byte value
        for (int v = 0; v < 256; v++) begin
            send_good(8'(v));
        end

        // Drain
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cycles(1);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
